// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: states, opcodes,
// funct codes, ALU operations and datapath select values.
package multicycle_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_IMMEX  = 4'd8;
  localparam logic [3:0] S_IMMWB  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;
  localparam logic [3:0] S_TRAP   = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_SLLV = 6'd4;
  localparam logic [5:0] FN_SRLV = 6'd6;
  localparam logic [5:0] FN_SRAV = 6'd7;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_FUNCT = 3'd6;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] IMM_SIGN = 2'b00;
  localparam logic [1:0] IMM_ZERO = 2'b01;
  localparam logic [1:0] IMM_LUI  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // R-type funct codes the datapath ALU can execute (jr is handled separately).
  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SLTU: funct_legal = 1'b1;
      default:                         funct_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Instruction classifier: picks the DECODE successor state and the ALU
// operation / immediate extension used by IMMEX.
module multicycle_ctrl_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] next_state,
  output logic [2:0] imm_alu_op,
  output logic [1:0] imm_sel
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_state = S_TRAP;
    imm_alu_op = ALU_ADD;
    imm_sel    = IMM_SIGN;
    case (opcode)
      OP_LW, OP_SW: next_state = S_MEMADR;
      OP_RTYPE: begin
        if (funct == FN_JR)          next_state = S_JR;
        else if (funct_legal(funct)) next_state = S_RTEX;
        else                         next_state = S_TRAP;
      end
      OP_BEQ, OP_BNE: next_state = S_BRANCH;
      OP_J:           next_state = S_JUMP;
      OP_JAL:         next_state = S_JAL;
      OP_ADDI: begin
        next_state = S_IMMEX;
      end
      OP_SLTI, OP_SLTIU: begin
        next_state = S_IMMEX;
        imm_alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        next_state = S_IMMEX;
        imm_alu_op = ALU_AND;
        imm_sel    = IMM_ZERO;
      end
      OP_ORI: begin
        next_state = S_IMMEX;
        imm_alu_op = ALU_OR;
        imm_sel    = IMM_ZERO;
      end
      OP_XORI: begin
        next_state = S_IMMEX;
        imm_alu_op = ALU_XOR;
        imm_sel    = IMM_ZERO;
      end
      OP_LUI: begin
        next_state = S_IMMEX;
        imm_sel    = IMM_LUI;
      end
      default: next_state = S_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes and selects from the current state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUOP_W   = 3,
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               reg_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_write_ne,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_sel,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         reg_dst,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [3:0]         state
);

  logic [3:0] state_q, state_d;
  logic [3:0] dec_next;
  logic [2:0] imm_alu_op, alu_op_c;
  logic [1:0] dec_imm_sel;

  multicycle_ctrl_dec u_dec (
    .opcode     (opcode),
    .funct      (funct),
    .next_state (dec_next),
    .imm_alu_op (imm_alu_op),
    .imm_sel    (dec_imm_sel)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_next;
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTEX:   state_d = S_RTWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_TRAP:   state_d = TRAP_HALT ? S_TRAP : S_FETCH;
      S_MEMWB, S_RTWB, S_IMMWB,
      S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_write_ne   = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    imm_sel       = IMM_SIGN;
    mem_to_reg    = M2R_ALUOUT;
    reg_dst       = RDST_RT;
    pc_src        = PCSRC_ALU;
    alu_op_c      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_BR;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_op_c  = ALU_FUNCT;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = RDST_RD;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op_c  = imm_alu_op;
        imm_sel   = dec_imm_sel;
      end
      S_IMMWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op_c      = ALU_SUB;
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = (opcode == OP_BEQ);
        pc_write_ne   = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RDST_RA;
        mem_to_reg = M2R_PC;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_RS;
      end
      default: ;
    endcase
    // Reset overrides the state decode so a half-finished access never commits.
    if (rst) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_write_ne   = 1'b0;
      alu_src_a     = 1'b0;
    end
  end

  assign alu_op  = ALUOP_W'(alu_op_c);
  assign illegal = (state_q == S_TRAP) && !rst;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes cycle by cycle
// and compares state, strobes and selects against hand-computed values.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       mem_ready;

  logic       mem_read, mem_write, iord, ir_write, reg_write, pc_write;
  logic       pc_write_cond, pc_write_ne, alu_src_a, illegal;
  logic [1:0] alu_src_b, imm_sel, mem_to_reg, reg_dst, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  logic       nh_mem_read, nh_mem_write, nh_iord, nh_ir_write, nh_reg_write, nh_pc_write;
  logic       nh_pc_write_cond, nh_pc_write_ne, nh_alu_src_a, nh_illegal;
  logic [1:0] nh_alu_src_b, nh_imm_sel, nh_mem_to_reg, nh_reg_dst, nh_pc_src;
  logic [2:0] nh_alu_op;
  logic [3:0] nh_state;

  // Strobe order: mem_read mem_write iord ir_write reg_write pc_write pc_write_cond pc_write_ne alu_src_a
  logic [8:0] stb, nh_stb;
  assign stb    = {mem_read, mem_write, iord, ir_write, reg_write, pc_write,
                   pc_write_cond, pc_write_ne, alu_src_a};
  assign nh_stb = {nh_mem_read, nh_mem_write, nh_iord, nh_ir_write, nh_reg_write, nh_pc_write,
                   nh_pc_write_cond, nh_pc_write_ne, nh_alu_src_a};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALUOP_W(3), .TRAP_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .reg_write(reg_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_write_ne(pc_write_ne), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_sel(imm_sel), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .pc_src(pc_src),
    .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  multicycle_ctrl #(.ALUOP_W(3), .TRAP_HALT(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_read(nh_mem_read), .mem_write(nh_mem_write), .iord(nh_iord), .ir_write(nh_ir_write),
    .reg_write(nh_reg_write), .pc_write(nh_pc_write), .pc_write_cond(nh_pc_write_cond),
    .pc_write_ne(nh_pc_write_ne), .alu_src_a(nh_alu_src_a), .alu_src_b(nh_alu_src_b),
    .imm_sel(nh_imm_sel), .mem_to_reg(nh_mem_to_reg), .reg_dst(nh_reg_dst), .pc_src(nh_pc_src),
    .alu_op(nh_alu_op), .illegal(nh_illegal), .state(nh_state)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic [8:0] s);
    check({tag, ".state"}, 16'(state), 16'(st));
    check({tag, ".stb"}, 16'(stb), 16'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = OP_RTYPE; funct = FN_ADD; mem_ready = 1'b1;
    tick();
    #1;
    check("rst.state", 16'(state), 16'(S_FETCH));
    check("rst.stb", 16'(stb), 16'h0);
    check("rst.illegal", 16'(illegal), 16'h0);
    tick();

    // add: FETCH DECODE RTEX RTWB, mem_ready ignored outside memory states
    rst = 1'b0;
    #1;
    cyc("add.fetch", S_FETCH, 9'h128);
    check("add.fetch.srcb", 16'(alu_src_b), 16'(2'b01));
    check("add.fetch.aluop", 16'(alu_op), 16'h0);
    tick();
    mem_ready = 1'b0;
    #1;
    cyc("add.decode", S_DECODE, 9'h000);
    check("add.decode.srcb", 16'(alu_src_b), 16'(2'b11));
    tick();
    #1;
    cyc("add.rtex", S_RTEX, 9'h001);
    check("add.rtex.aluop", 16'(alu_op), 16'h6);
    check("add.rtex.srcb", 16'(alu_src_b), 16'(2'b00));
    tick();
    #1;
    cyc("add.rtwb", S_RTWB, 9'h010);
    check("add.rtwb.regdst", 16'(reg_dst), 16'(2'b01));
    check("add.rtwb.m2r", 16'(mem_to_reg), 16'(2'b00));
    tick();

    // lw with two memory wait cycles in MEMRD: 7 cycles
    opcode = OP_LW; mem_ready = 1'b1;
    #1;
    cyc("lw.fetch", S_FETCH, 9'h128);
    tick();
    #1;
    cyc("lw.decode", S_DECODE, 9'h000);
    tick();
    #1;
    cyc("lw.memadr", S_MEMADR, 9'h001);
    check("lw.memadr.srcb", 16'(alu_src_b), 16'(2'b10));
    check("lw.memadr.immsel", 16'(imm_sel), 16'(2'b00));
    tick();
    mem_ready = 1'b0;
    #1;
    cyc("lw.memrd.w1", S_MEMRD, 9'h140);
    tick();
    #1;
    cyc("lw.memrd.w2", S_MEMRD, 9'h140);
    tick();
    mem_ready = 1'b1;
    #1;
    cyc("lw.memrd.rdy", S_MEMRD, 9'h140);
    tick();
    #1;
    cyc("lw.memwb", S_MEMWB, 9'h010);
    check("lw.memwb.m2r", 16'(mem_to_reg), 16'(2'b01));
    check("lw.memwb.regdst", 16'(reg_dst), 16'(2'b00));
    tick();

    // sw with a fetch wait and a MEMWR wait
    opcode = OP_SW; mem_ready = 1'b0;
    #1;
    cyc("sw.fetch.wait", S_FETCH, 9'h100);
    tick();
    mem_ready = 1'b1;
    #1;
    cyc("sw.fetch", S_FETCH, 9'h128);
    tick();
    #1;
    cyc("sw.decode", S_DECODE, 9'h000);
    tick();
    #1;
    cyc("sw.memadr", S_MEMADR, 9'h001);
    tick();
    mem_ready = 1'b0;
    #1;
    cyc("sw.memwr.wait", S_MEMWR, 9'h0C0);
    tick();
    mem_ready = 1'b1;
    #1;
    cyc("sw.memwr.rdy", S_MEMWR, 9'h0C0);
    tick();

    // bne
    opcode = OP_BNE;
    #1;
    cyc("bne.fetch", S_FETCH, 9'h128);
    tick();
    tick();
    #1;
    cyc("bne.branch", S_BRANCH, 9'h003);
    check("bne.aluop", 16'(alu_op), 16'h1);
    check("bne.pcsrc", 16'(pc_src), 16'(2'b01));
    tick();

    // beq
    opcode = OP_BEQ;
    tick();
    tick();
    #1;
    cyc("beq.branch", S_BRANCH, 9'h005);
    tick();

    // jal
    opcode = OP_JAL;
    tick();
    tick();
    #1;
    cyc("jal.jal", S_JAL, 9'h018);
    check("jal.regdst", 16'(reg_dst), 16'(2'b10));
    check("jal.m2r", 16'(mem_to_reg), 16'(2'b10));
    check("jal.pcsrc", 16'(pc_src), 16'(2'b10));
    tick();

    // jr
    opcode = OP_RTYPE; funct = FN_JR;
    tick();
    tick();
    #1;
    cyc("jr.jr", S_JR, 9'h008);
    check("jr.pcsrc", 16'(pc_src), 16'(2'b11));
    tick();

    // j
    opcode = OP_J;
    tick();
    tick();
    #1;
    cyc("j.jump", S_JUMP, 9'h008);
    check("j.pcsrc", 16'(pc_src), 16'(2'b10));
    tick();

    // ori: or with zero extension
    opcode = OP_ORI;
    tick();
    tick();
    #1;
    cyc("ori.immex", S_IMMEX, 9'h001);
    check("ori.aluop", 16'(alu_op), 16'h3);
    check("ori.immsel", 16'(imm_sel), 16'(2'b01));
    check("ori.srcb", 16'(alu_src_b), 16'(2'b10));
    tick();
    #1;
    cyc("ori.immwb", S_IMMWB, 9'h010);
    check("ori.regdst", 16'(reg_dst), 16'(2'b00));
    tick();

    // lui and slti selections
    opcode = OP_LUI;
    tick();
    tick();
    #1;
    check("lui.aluop", 16'(alu_op), 16'h0);
    check("lui.immsel", 16'(imm_sel), 16'(2'b10));
    tick();
    tick();
    opcode = OP_SLTI;
    tick();
    tick();
    #1;
    check("slti.aluop", 16'(alu_op), 16'h5);
    check("slti.immsel", 16'(imm_sel), 16'(2'b00));
    tick();
    tick();

    // reset asserted while MEMWR waits
    opcode = OP_SW;
    #1;
    cyc("swr.fetch", S_FETCH, 9'h128);
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    cyc("swr.memwr", S_MEMWR, 9'h0C0);
    tick();
    rst = 1'b1;
    #1;
    check("swr.rst.stb", 16'(stb), 16'h0);
    tick();
    rst = 1'b0;
    #1;
    cyc("swr.after", S_FETCH, 9'h100);

    // illegal opcode: halting vs non-halting trap
    opcode = 6'd63; mem_ready = 1'b1;
    tick();
    tick();
    #1;
    cyc("trap.enter", S_TRAP, 9'h000);
    check("trap.illegal", 16'(illegal), 16'h1);
    check("trap.nh.illegal", 16'(nh_illegal), 16'h1);
    check("trap.nh.stb", 16'(nh_stb), 16'h0);
    tick();
    #1;
    check("trap.nh.state", 16'(nh_state), 16'(S_FETCH));
    check("trap.nh.illegal_off", 16'(nh_illegal), 16'h0);
    for (int i = 0; i < 10; i++) begin
      check("trap.hold.illegal", 16'(illegal), 16'h1);
      cyc("trap.hold", S_TRAP, 9'h000);
      tick();
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("trap.rst.illegal", 16'(illegal), 16'h0);
    cyc("trap.rst", S_FETCH, 9'h128);

    // unsupported R-type funct traps
    opcode = OP_RTYPE; funct = 6'd1;
    tick();
    tick();
    #1;
    cyc("badfn.trap", S_TRAP, 9'h000);
    check("badfn.illegal", 16'(illegal), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
